// File: rtl/priority_encoder_4x2_seq.sv
// priority_encoder_4x2_seq
// Registered 4-to-2 priority encoder with request latching and a valid/ack
// handshake. Requests on D are collected into a pending register while
// enable is high; one pending index at a time is presented on Y with valid,
// and the consumer retires it by asserting ack.
//
// Configuration macro: ENC_ROUND_ROBIN_EN
//   undefined : fixed priority, bit 3 highest (3 > 2 > 1 > 0)
//   defined   : rotating priority; the most recently acked index becomes
//               the lowest priority for the next search
module priority_encoder_4x2_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [3:0] D,
   input  logic       ack,
   output logic [1:0] Y,
   output logic       valid,
   output logic [3:0] pending
);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [1:0] y_next;
   logic [1:0] sel;
   logic [3:0] pend_next;
   logic [3:0] clr;
   logic [3:0] set;
   logic       accept;

`ifdef ENC_ROUND_ROBIN_EN
   logic [1:0] last;
   logic [1:0] last_next;

   // Rotating search: last-1, last-2, ... (mod 4), with base itself lowest.
   function automatic logic [1:0] select_req(input logic [3:0] req,
                                             input logic [1:0] base);
      logic [1:0] idx;
      logic [1:0] pick;
      logic       found;
      pick  = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= 4; k++) begin
         idx = base - 2'(k);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction
`else
   // Fixed-priority search, bit 3 highest.
   function automatic logic [1:0] select_req(input logic [3:0] req);
      logic [1:0] pick;
      pick = '0;
      if (req[3])      pick = 2'd3;
      else if (req[2]) pick = 2'd2;
      else if (req[1]) pick = 2'd1;
      else             pick = 2'd0;
      return pick;
   endfunction
`endif

   assign valid = (state == PRESENT);

   // Pending-register update: set (new captures) wins over clear (ack).
   always_comb begin
      accept    = valid & ack;
      clr       = accept ? (4'b0001 << Y) : '0;
      set       = enable ? D : '0;
      pend_next = (pending & ~clr) | set;
`ifdef ENC_ROUND_ROBIN_EN
      // The index being acked this cycle already ranks lowest for the
      // search that picks its successor, so no bubble is needed.
      last_next = accept ? Y : last;
      sel       = select_req(pend_next, last_next);
`else
      sel       = select_req(pend_next);
`endif
   end

   // Next-state and next-index logic; no preemption while presenting.
   always_comb begin
      state_next = state;
      y_next     = Y;
      case (state)
         IDLE: begin
            if (pend_next != '0) begin
               state_next = PRESENT;
               y_next     = sel;
            end
         end
         PRESENT: begin
            if (accept) begin
               if (pend_next != '0) begin
                  y_next = sel;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, index and pending registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         Y       <= '0;
         pending <= '0;
      end else begin
         state   <= state_next;
         Y       <= y_next;
         pending <= pend_next;
      end
   end

`ifdef ENC_ROUND_ROBIN_EN
   // Most recently acked index; reset to 0 so the first order is 3,2,1,0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= '0;
      end else begin
         last <= last_next;
      end
   end
`endif

endmodule

// File: tb/tb_priority_encoder_4x2_seq.sv
// tb_priority_encoder_4x2_seq
// Directed-vector bench for priority_encoder_4x2_seq. Expected values are
// hand-computed; define ENC_ROUND_ROBIN_EN for both files to check the
// rotating-priority build.
module tb_priority_encoder_4x2_seq;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic [3:0] D;
   logic       ack;
   logic [1:0] Y;
   logic       valid;
   logic [3:0] pending;

   int unsigned n_checks;
   int unsigned n_pass;

   priority_encoder_4x2_seq dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .D       (D),
      .ack     (ack),
      .Y       (Y),
      .valid   (valid),
      .pending (pending)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [3:0] got,
                        input logic [3:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle 1 ns past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [1:0] ey,
                            input logic ev, input logic [3:0] ep);
      check({tag, ".Y"},       {2'b00, Y},     {2'b00, ey});
      check({tag, ".valid"},   {3'b000, valid}, {3'b000, ev});
      check({tag, ".pending"}, pending,         ep);
   endtask

   logic [1:0] rr_exp [6];

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      enable   = 1'b1;
      D        = 4'b1111;
      ack      = 1'b0;

      // Reset held with requests present.
      step();
      step();
      check_out("reset_hold", 2'd0, 1'b0, 4'b0000);
      rst_n = 1'b1;

      // Multi-hot drain.
      D = 4'b0101;
      step();
      check_out("mh_capture", 2'd2, 1'b1, 4'b0101);
      D   = 4'b0000;
      ack = 1'b1;
      step();
      check_out("mh_ack1", 2'd0, 1'b1, 4'b0001);
      step();
      check_out("mh_ack2", 2'd0, 1'b0, 4'b0000);
      ack = 1'b0;

      // Enable gating.
      enable = 1'b0;
      D      = 4'b1111;
      for (int i = 0; i < 5; i++) step();
      check_out("en_gated", 2'd0, 1'b0, 4'b0000);
      enable = 1'b1;
      step();
      check_out("en_capture", 2'd3, 1'b1, 4'b1111);

      // Drain with capture disabled: pending bits still retired.
      enable = 1'b0;
      ack    = 1'b1;
      step();
      check_out("drain_a", 2'd2, 1'b1, 4'b0111);
      step();
      check_out("drain_b", 2'd1, 1'b1, 4'b0011);
      step();
      check_out("drain_c", 2'd0, 1'b1, 4'b0001);
      step();
      check_out("drain_end", 2'd0, 1'b0, 4'b0000);

      // Ack while idle is ignored.
      step();
      check_out("idle_ack", 2'd0, 1'b0, 4'b0000);
      ack = 1'b0;

      // No preemption.
      enable = 1'b1;
      D      = 4'b0001;
      step();
      check_out("np_low", 2'd0, 1'b1, 4'b0001);
      D = 4'b1000;
      step();
      check_out("np_hold", 2'd0, 1'b1, 4'b1001);
      D   = 4'b0000;
      ack = 1'b1;
      step();
      check_out("np_next", 2'd3, 1'b1, 4'b1000);
      step();
      check_out("np_end", 2'd3, 1'b0, 4'b0000);
      ack = 1'b0;

      // Simultaneous ack and re-request of the same bit.
      D = 4'b0100;
      step();
      check_out("rr_set", 2'd2, 1'b1, 4'b0100);
      ack = 1'b1;
      step();
      check_out("rereq", 2'd2, 1'b1, 4'b0100);
      D = 4'b0000;
      step();
      check_out("rereq_end", 2'd2, 1'b0, 4'b0000);
      ack = 1'b0;

      // Asynchronous reset mid-PRESENT, between edges.
      D = 4'b0010;
      step();
      check_out("pre_rst", 2'd1, 1'b1, 4'b0010);
      D = 4'b0000;
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async_rst", 2'd0, 1'b0, 4'b0000);
      step();
      rst_n = 1'b1;

      // All requests held with continuous ack.
`ifdef ENC_ROUND_ROBIN_EN
      rr_exp = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};
`else
      rr_exp = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
      enable = 1'b1;
      D      = 4'b1111;
      ack    = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("all_req[%0d].Y", i), {2'b00, Y}, {2'b00, rr_exp[i]});
         check($sformatf("all_req[%0d].valid", i), {3'b000, valid}, 4'b0001);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
